// File: rtl/tl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tl_arbiter
// Description : N-master to 1-slave TileLink-UL arbiter. Round-robin A-channel
//               merge through one registered stage, source-tag D steering,
//               per-master outstanding-request limit.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int SRC_W           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MASTERS*3-1:0]              m_a_opcode,
  input  logic [NUM_MASTERS*3-1:0]              m_a_param,
  input  logic [NUM_MASTERS*3-1:0]              m_a_size,
  input  logic [NUM_MASTERS*SRC_W-1:0]          m_a_source,
  input  logic [NUM_MASTERS*64-1:0]             m_a_address,
  input  logic [NUM_MASTERS*64-1:0]             m_a_data,
  input  logic [NUM_MASTERS*8-1:0]              m_a_mask,
  input  logic [NUM_MASTERS-1:0]                m_a_corrupt,
  input  logic [NUM_MASTERS-1:0]                m_a_valid,
  output logic [NUM_MASTERS-1:0]                m_a_ready,
  output logic [NUM_MASTERS*3-1:0]              m_d_opcode,
  output logic [NUM_MASTERS*2-1:0]              m_d_param,
  output logic [NUM_MASTERS*3-1:0]              m_d_size,
  output logic [NUM_MASTERS*SRC_W-1:0]          m_d_source,
  output logic [NUM_MASTERS*6-1:0]              m_d_sink,
  output logic [NUM_MASTERS*64-1:0]             m_d_data,
  output logic [NUM_MASTERS-1:0]                m_d_denied,
  output logic [NUM_MASTERS-1:0]                m_d_corrupt,
  output logic [NUM_MASTERS-1:0]                m_d_valid,
  input  logic [NUM_MASTERS-1:0]                m_d_ready,
  output logic [2:0]                            s_a_opcode,
  output logic [2:0]                            s_a_param,
  output logic [2:0]                            s_a_size,
  output logic [SRC_W+$clog2(NUM_MASTERS)-1:0]  s_a_source,
  output logic [63:0]                           s_a_address,
  output logic [63:0]                           s_a_data,
  output logic [7:0]                            s_a_mask,
  output logic                                  s_a_corrupt,
  output logic                                  s_a_valid,
  input  logic                                  s_a_ready,
  input  logic [2:0]                            s_d_opcode,
  input  logic [1:0]                            s_d_param,
  input  logic [2:0]                            s_d_size,
  input  logic [SRC_W+$clog2(NUM_MASTERS)-1:0]  s_d_source,
  input  logic [5:0]                            s_d_sink,
  input  logic [63:0]                           s_d_data,
  input  logic                                  s_d_denied,
  input  logic                                  s_d_corrupt,
  input  logic                                  s_d_valid,
  output logic                                  s_d_ready
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0][3:0] r_cnt;
  logic [IDX_W-1:0]            r_rr_ptr;
  logic                        r_full;
  logic [2:0]                  r_opcode, r_param, r_size;
  logic [SRC_W+IDX_W-1:0]      r_source;
  logic [63:0]                 r_address, r_data;
  logic [7:0]                  r_mask;
  logic                        r_corrupt;

  logic [NUM_MASTERS-1:0] w_elig, w_inc, w_dec;
  logic                   w_found, w_can_load, w_load;
  logic [IDX_W-1:0]       w_winner, w_d_idx;
  logic [2:0]             w_sel_opcode, w_sel_param, w_sel_size;
  logic [SRC_W-1:0]       w_sel_source;
  logic [63:0]            w_sel_address, w_sel_data;
  logic [7:0]             w_sel_mask;
  logic                   w_sel_corrupt;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++)
      w_elig[i] = m_a_valid[i] && (r_cnt[i] < 4'(MAX_OUTSTANDING));
  end

  // First eligible master at or after the priority pointer, wrapping around
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NUM_MASTERS]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'((int'(r_rr_ptr) + k) % NUM_MASTERS);
      end
    end
  end

  assign w_can_load = !r_full || s_a_ready;
  assign w_load     = w_found && w_can_load && !rst;

  always_comb begin
    w_sel_opcode  = '0;
    w_sel_param   = '0;
    w_sel_size    = '0;
    w_sel_source  = '0;
    w_sel_address = '0;
    w_sel_data    = '0;
    w_sel_mask    = '0;
    w_sel_corrupt = 1'b0;
    m_a_ready     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_sel_opcode  = m_a_opcode[i*3 +: 3];
        w_sel_param   = m_a_param[i*3 +: 3];
        w_sel_size    = m_a_size[i*3 +: 3];
        w_sel_source  = m_a_source[i*SRC_W +: SRC_W];
        w_sel_address = m_a_address[i*64 +: 64];
        w_sel_data    = m_a_data[i*64 +: 64];
        w_sel_mask    = m_a_mask[i*8 +: 8];
        w_sel_corrupt = m_a_corrupt[i];
        m_a_ready[i]  = w_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 1'b0;
      r_rr_ptr  <= '0;
      r_opcode  <= '0;
      r_param   <= '0;
      r_size    <= '0;
      r_source  <= '0;
      r_address <= '0;
      r_data    <= '0;
      r_mask    <= '0;
      r_corrupt <= 1'b0;
    end else if (w_load) begin
      r_full    <= 1'b1;
      r_rr_ptr  <= (w_winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_winner + 1'b1;
      r_opcode  <= w_sel_opcode;
      r_param   <= w_sel_param;
      r_size    <= w_sel_size;
      r_source  <= {w_winner, w_sel_source};
      r_address <= w_sel_address;
      r_data    <= w_sel_data;
      r_mask    <= w_sel_mask;
      r_corrupt <= w_sel_corrupt;
    end else if (s_a_ready) begin
      r_full    <= 1'b0;
    end
  end

  assign s_a_valid   = r_full;
  assign s_a_opcode  = r_opcode;
  assign s_a_param   = r_param;
  assign s_a_size    = r_size;
  assign s_a_source  = r_source;
  assign s_a_address = r_address;
  assign s_a_data    = r_data;
  assign s_a_mask    = r_mask;
  assign s_a_corrupt = r_corrupt;

  // Out-of-range tags match no master: response is dropped with ready held high
  assign w_d_idx = s_d_source[SRC_W+IDX_W-1:SRC_W];

  always_comb begin
    s_d_ready = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (w_d_idx == IDX_W'(i)) s_d_ready = m_d_ready[i];
  end

  generate
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_dport
      assign m_d_valid[g]                  = s_d_valid && (w_d_idx == IDX_W'(g));
      assign m_d_source[g*SRC_W +: SRC_W]  = s_d_source[SRC_W-1:0];
      assign m_d_opcode[g*3 +: 3]          = s_d_opcode;
      assign m_d_param[g*2 +: 2]           = s_d_param;
      assign m_d_size[g*3 +: 3]            = s_d_size;
      assign m_d_sink[g*6 +: 6]            = s_d_sink;
      assign m_d_data[g*64 +: 64]          = s_d_data;
      assign m_d_denied[g]                 = s_d_denied;
      assign m_d_corrupt[g]                = s_d_corrupt;
      assign w_inc[g]                      = m_a_valid[g] && m_a_ready[g];
      assign w_dec[g]                      = m_d_valid[g] && m_d_ready[g];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 4'd1;
        else if (!w_inc[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_arbiter
// Description : Directed self-checking bench for tl_arbiter (4 masters, limit 2)
//               plus a 3-master instance for out-of-range D tags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0]  m_a_opcode = '0, m_a_param = '0, m_a_size = '0;
  logic [15:0]  m_a_source = '0;
  logic [255:0] m_a_address = '0, m_a_data = '0;
  logic [31:0]  m_a_mask = '0;
  logic [3:0]   m_a_corrupt = '0, m_a_valid = '0, m_a_ready;
  logic [11:0]  m_d_opcode, m_d_size;
  logic [7:0]   m_d_param;
  logic [15:0]  m_d_source;
  logic [23:0]  m_d_sink;
  logic [255:0] m_d_data;
  logic [3:0]   m_d_denied, m_d_corrupt, m_d_valid;
  logic [3:0]   m_d_ready = '0;
  logic [2:0]   s_a_opcode, s_a_param, s_a_size;
  logic [5:0]   s_a_source;
  logic [63:0]  s_a_address, s_a_data;
  logic [7:0]   s_a_mask;
  logic         s_a_corrupt, s_a_valid;
  logic         s_a_ready = 1'b0;
  logic [2:0]   s_d_opcode = 3'd1, s_d_size = 3'd2;
  logic [1:0]   s_d_param = '0;
  logic [5:0]   s_d_source = '0, s_d_sink = 6'h2A;
  logic [63:0]  s_d_data = '0;
  logic         s_d_denied = 1'b0, s_d_corrupt = 1'b0, s_d_valid = 1'b0;
  logic         s_d_ready;

  tl_arbiter #(.NUM_MASTERS(4), .SRC_W(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
    .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_data(m_a_data),
    .m_a_mask(m_a_mask), .m_a_corrupt(m_a_corrupt), .m_a_valid(m_a_valid),
    .m_a_ready(m_a_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_sink(m_d_sink), .m_d_data(m_d_data),
    .m_d_denied(m_d_denied), .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid),
    .m_d_ready(m_d_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_data(s_a_data),
    .s_a_mask(s_a_mask), .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid),
    .s_a_ready(s_a_ready),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_source(s_d_source), .s_d_sink(s_d_sink), .s_d_data(s_d_data),
    .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt), .s_d_valid(s_d_valid),
    .s_d_ready(s_d_ready)
  );

  // Three-master instance: a 2-bit tag can name a non-existent master
  logic [8:0]   b_m_a_3 = '0;
  logic [11:0]  b_m_a_source = '0;
  logic [191:0] b_m_a_wide = '0;
  logic [23:0]  b_m_a_mask = '0;
  logic [2:0]   b_m_a_bits = '0, b_m_a_ready;
  logic [8:0]   b_m_d_opcode, b_m_d_size;
  logic [5:0]   b_m_d_param;
  logic [11:0]  b_m_d_source;
  logic [17:0]  b_m_d_sink;
  logic [191:0] b_m_d_data;
  logic [2:0]   b_m_d_denied, b_m_d_corrupt, b_m_d_valid;
  logic [2:0]   b_m_d_ready = '0;
  logic [2:0]   b_s_a_opcode, b_s_a_param, b_s_a_size;
  logic [5:0]   b_s_a_source;
  logic [63:0]  b_s_a_address, b_s_a_data;
  logic [7:0]   b_s_a_mask;
  logic         b_s_a_corrupt, b_s_a_valid;
  logic [5:0]   b_s_d_source = '0;
  logic         b_s_d_valid = 1'b0, b_s_d_ready;

  tl_arbiter #(.NUM_MASTERS(3), .SRC_W(4), .MAX_OUTSTANDING(2)) dut3 (
    .clk(clk), .rst(rst),
    .m_a_opcode(b_m_a_3), .m_a_param(b_m_a_3), .m_a_size(b_m_a_3),
    .m_a_source(b_m_a_source), .m_a_address(b_m_a_wide), .m_a_data(b_m_a_wide),
    .m_a_mask(b_m_a_mask), .m_a_corrupt(b_m_a_bits), .m_a_valid(b_m_a_bits),
    .m_a_ready(b_m_a_ready),
    .m_d_opcode(b_m_d_opcode), .m_d_param(b_m_d_param), .m_d_size(b_m_d_size),
    .m_d_source(b_m_d_source), .m_d_sink(b_m_d_sink), .m_d_data(b_m_d_data),
    .m_d_denied(b_m_d_denied), .m_d_corrupt(b_m_d_corrupt), .m_d_valid(b_m_d_valid),
    .m_d_ready(b_m_d_ready),
    .s_a_opcode(b_s_a_opcode), .s_a_param(b_s_a_param), .s_a_size(b_s_a_size),
    .s_a_source(b_s_a_source), .s_a_address(b_s_a_address), .s_a_data(b_s_a_data),
    .s_a_mask(b_s_a_mask), .s_a_corrupt(b_s_a_corrupt), .s_a_valid(b_s_a_valid),
    .s_a_ready(1'b1),
    .s_d_opcode(3'd1), .s_d_param(2'd0), .s_d_size(3'd2),
    .s_d_source(b_s_d_source), .s_d_sink(6'd0), .s_d_data(64'd0),
    .s_d_denied(1'b0), .s_d_corrupt(1'b0), .s_d_valid(b_s_d_valid),
    .s_d_ready(b_s_d_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_m(input int i, input logic v, input logic [3:0] src, input logic [63:0] addr);
    m_a_valid[i]            = v;
    m_a_opcode[i*3 +: 3]    = 3'd4;
    m_a_size[i*3 +: 3]      = 3'd2;
    m_a_source[i*4 +: 4]    = src;
    m_a_address[i*64 +: 64] = addr;
    m_a_data[i*64 +: 64]    = addr ^ 64'hA5A5_0000_0000_5A5A;
    m_a_mask[i*8 +: 8]      = 8'h0F;
  endtask

  // Bench slave: answers the beat it is accepting this cycle, for enabled masters
  task automatic auto_d(input logic [3:0] en);
    s_d_valid  = s_a_valid && en[s_a_source[5:4]];
    s_d_source = s_a_source;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_a_valid = '0; s_d_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        assert (!(m_d_valid[i] && m_d_ready[i] && dut.r_cnt[i] == 4'd0))
        else begin
          failures++;
          $display("FAIL cnt_underflow: master %0d got D handshake at count 0", i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       sv;
    logic [5:0] src;
    logic [3:0] mrdy;
    logic [3:0] exp_mv;
    logic       exp_sr;
  } dvec_t;
  dvec_t dv[6];

  logic [3:0] t4_exp[6];
  logic [5:0] e_src;
  int idx;

  initial begin
    dv[0] = '{1'b1, 6'h25, 4'b0100, 4'b0100, 1'b1};
    dv[1] = '{1'b1, 6'h25, 4'b1011, 4'b0100, 1'b0};
    dv[2] = '{1'b0, 6'h3A, 4'b1000, 4'b0000, 1'b1};
    dv[3] = '{1'b1, 6'h0F, 4'b0001, 4'b0001, 1'b1};
    dv[4] = '{1'b1, 6'h31, 4'b0111, 4'b1000, 1'b0};
    dv[5] = '{1'b1, 6'h1C, 4'b0010, 4'b0010, 1'b1};
    t4_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0010};

    // Reset state, with every master requesting
    m_a_valid = 4'hF; s_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 4'(i), 64'h100 * (i + 1));
    repeat (2) @(negedge clk);
    #1;
    check("rst_s_valid", s_a_valid, 0);
    check("rst_m_ready", m_a_ready, 0);
    check("rst_s_source", s_a_source, 0);
    check("rst_s_addr", s_a_address, 0);
    check("rst_rr", dut.r_rr_ptr, 0);
    check("rst_cnt", dut.r_cnt, 0);

    // Combinational D routing table (held in reset so counters are untouched)
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s_d_valid = dv[k].sv; s_d_source = dv[k].src; m_d_ready = dv[k].mrdy;
      s_d_data = 64'hD00D_0000_0000_0000 | 64'(k);
      #1;
      idx = int'(dv[k].src[5:4]);
      check("d_valid", m_d_valid, dv[k].exp_mv);
      check("d_ready", s_d_ready, dv[k].exp_sr);
      check("d_source", m_d_source[idx*4 +: 4], dv[k].src[3:0]);
      check("d_data_bcast", m_d_data[(3 - idx)*64 +: 64], 64'hD00D_0000_0000_0000 | 64'(k));
      check("d_sink_bcast", m_d_sink[0 +: 6], 6'h2A);
    end

    // 1: single request from master 2
    do_reset();
    s_a_ready = 1'b1; m_d_ready = 4'hF;
    set_m(2, 1'b1, 4'd5, 64'h8000_0000);
    #1;
    check("t1_grant", m_a_ready, 4'b0100);
    @(negedge clk); m_a_valid = '0; #1;
    check("t1_s_valid", s_a_valid, 1);
    check("t1_s_source", s_a_source, 6'h25);
    check("t1_s_addr", s_a_address, 64'h8000_0000);
    check("t1_s_opcode", s_a_opcode, 3'd4);
    check("t1_cnt2", dut.r_cnt[2], 1);
    check("t1_rr", dut.r_rr_ptr, 3);
    @(negedge clk);
    s_d_valid = 1'b1; s_d_source = 6'h25; m_d_ready = 4'b0100; #1;
    check("t1_s_drained", s_a_valid, 0);
    check("t1_d_valid", m_d_valid, 4'b0100);
    check("t1_d_source", m_d_source[8 +: 4], 4'd5);
    check("t1_d_ready", s_d_ready, 1);
    @(negedge clk); s_d_valid = 1'b0; m_d_ready = 4'hF; #1;
    check("t1_cnt2_back", dut.r_cnt[2], 0);

    // 2: round-robin with all masters requesting, prompt responses
    do_reset();
    s_a_ready = 1'b1; m_d_ready = 4'hF;
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 4'(i + 8), 64'h1000 * (i + 1));
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      auto_d(4'hF);
      #1;
      check("t2_grant", m_a_ready, 64'(1) << (c % 4));
      if (c > 0) begin
        e_src = 6'(((c - 1) % 4) * 16 + ((c - 1) % 4) + 8);
        check("t2_s_valid", s_a_valid, 1);
        check("t2_s_source", s_a_source, e_src);
      end
    end
    @(negedge clk); m_a_valid = '0; auto_d(4'hF); #1;
    check("t2_last_beat", s_a_source, 6'h3B);
    check("t2_no_grant", m_a_ready, 0);
    @(negedge clk); s_d_valid = 1'b0; #1;
    check("t2_cnt_zero", dut.r_cnt, 0);

    // 3: slave stall holds the stage
    do_reset();
    s_a_ready = 1'b0; m_d_ready = 4'hF;
    set_m(1, 1'b1, 4'd3, 64'h1000);
    #1;
    check("t3_grant", m_a_ready, 4'b0010);
    @(negedge clk); set_m(1, 1'b1, 4'd3, 64'h2000); #1;
    check("t3_s_valid", s_a_valid, 1);
    check("t3_s_source", s_a_source, 6'h13);
    check("t3_no_grant", m_a_ready, 0);
    repeat (5) begin
      @(negedge clk); #1;
      check("t3_stall_addr", s_a_address, 64'h1000);
      check("t3_stall_valid", s_a_valid, 1);
      check("t3_stall_ready", m_a_ready, 0);
    end
    @(negedge clk); s_a_ready = 1'b1; #1;
    check("t3_resume_grant", m_a_ready, 4'b0010);
    @(negedge clk); #1;
    check("t3_next_addr", s_a_address, 64'h2000);
    check("t3_next_valid", s_a_valid, 1);
    check("t3_at_limit", m_a_ready, 0);
    check("t3_cnt1", dut.r_cnt[1], 2);

    // 4: outstanding limit on master 0, master 1 served promptly
    do_reset();
    s_a_ready = 1'b1; m_d_ready = 4'hF;
    set_m(0, 1'b1, 4'd1, 64'h40);
    set_m(1, 1'b1, 4'd2, 64'h80);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      auto_d(4'b0010);
      #1;
      check("t4_grant", m_a_ready, t4_exp[c]);
    end
    @(negedge clk); m_a_valid[1] = 1'b0; auto_d(4'b0010); #1;
    check("t4_blocked", m_a_ready, 0);
    check("t4_cnt0", dut.r_cnt[0], 2);
    @(negedge clk); s_d_valid = 1'b1; s_d_source = 6'h01; #1;
    check("t4_still_blocked", m_a_ready, 0);
    check("t4_d_to_m0", m_d_valid, 4'b0001);
    @(negedge clk); s_d_valid = 1'b0; #1;
    check("t4_reenabled", m_a_ready, 4'b0001);

    // 5: same-cycle A and D handshakes on master 3; routed backpressure
    do_reset();
    s_a_ready = 1'b1; m_d_ready = 4'hF;
    set_m(3, 1'b1, 4'd7, 64'hC0);
    #1;
    check("t5_grant", m_a_ready, 4'b1000);
    @(negedge clk); auto_d(4'b1000); #1;
    check("t5_grant2", m_a_ready, 4'b1000);
    check("t5_d_valid", m_d_valid, 4'b1000);
    @(negedge clk);
    m_a_valid = '0; s_d_valid = 1'b1; s_d_source = 6'h37; m_d_ready = 4'b0111; #1;
    check("t5_cnt_same", dut.r_cnt[3], 1);
    check("t5_d_backpressure", s_d_ready, 0);
    check("t5_d_valid_held", m_d_valid, 4'b1000);
    @(negedge clk); #1;
    check("t5_cnt_held", dut.r_cnt[3], 1);
    m_d_ready = 4'hF;
    @(negedge clk); s_d_valid = 1'b0; #1;
    check("t5_cnt_done", dut.r_cnt[3], 0);

    // 6: reset with the stage full and a count outstanding
    do_reset();
    s_a_ready = 1'b0;
    set_m(0, 1'b1, 4'd1, 64'h11);
    set_m(1, 1'b1, 4'd2, 64'h22);
    #1;
    check("t6_grant", m_a_ready, 4'b0001);
    @(negedge clk); #1;
    check("t6_full", s_a_valid, 1);
    check("t6_cnt0", dut.r_cnt[0], 1);
    check("t6_rr", dut.r_rr_ptr, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("t6_rst_valid", s_a_valid, 0);
    check("t6_rst_cnt", dut.r_cnt, 0);
    check("t6_rst_rr", dut.r_rr_ptr, 0);
    check("t6_rst_ready", m_a_ready, 0);
    rst = 1'b0; #1;
    check("t6_after_rst", m_a_ready, 4'b0001);

    // Out-of-range tag on the 3-master instance
    @(negedge clk);
    m_a_valid = '0;
    b_s_d_valid = 1'b1; b_s_d_source = 6'h35; b_m_d_ready = 3'b000; #1;
    check("oor_no_valid", b_m_d_valid, 0);
    check("oor_ready", b_s_d_ready, 1);
    b_s_d_source = 6'h27; b_m_d_ready = 3'b011; #1;
    check("n3_valid", b_m_d_valid, 3'b100);
    check("n3_ready", b_s_d_ready, 0);
    b_s_d_valid = 1'b0;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
